// File: rtl/ps_bigreg_collector.sv
// PS_BIGREG collector: assembles SAMPLES mem-map words into one wide register,
// commits it on a VALID_ID write into a small FIFO read by RTL consumers.
module ps_bigreg_collector #(
   parameter int unsigned MEM_SIZE     = 256,
   parameter int unsigned WORD_WIDTH   = 16,
   parameter int unsigned BIGREG_WIDTH = 256,
   parameter int unsigned BASE_ID      = 33,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STRICT       = 1,
   localparam int unsigned IDW         = $clog2(MEM_SIZE),
   localparam int unsigned SAMPLES     = BIGREG_WIDTH / WORD_WIDTH,
   localparam int unsigned VALID_ID    = BASE_ID + SAMPLES,
   localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [IDW-1:0]          wr_id,
   input  logic [WORD_WIDTH-1:0]   wr_data,
   output logic                    wr_resp_valid,
   output logic [1:0]              wr_resp,
   output logic [SAMPLES:0]        fresh,
   output logic [BIGREG_WIDTH-1:0] bigreg_data,
   output logic                    bigreg_valid,
   input  logic                    bigreg_ready,
   output logic [CW-1:0]           pending,
   output logic [7:0]              reject_cnt
);

   localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0]  RESP_OKAY = 2'b00;
   localparam logic [1:0]  RESP_SLV  = 2'b10;

   if ((BIGREG_WIDTH % WORD_WIDTH) != 0) begin : g_err_width
      $error("BIGREG_WIDTH must be a multiple of WORD_WIDTH");
   end
   if (VALID_ID >= MEM_SIZE) begin : g_err_range
      $error("VALID_ID falls outside the mem-map");
   end

   logic [BIGREG_WIDTH-1:0] r_staging;
   logic [SAMPLES:0]        r_fresh;
   logic [BIGREG_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]           r_wr_ptr;
   logic [PW-1:0]           r_rd_ptr;
   logic [CW-1:0]           r_count;
   logic                    r_resp_valid;
   logic [1:0]              r_resp;
   logic [7:0]              r_reject_cnt;

   logic           w_word_hit;
   logic           w_commit;
   logic [IDW-1:0] w_idx;
   logic           w_all_fresh;
   logic           w_pop;
   logic           w_full;
   logic           w_accept;
   logic           w_reject;

   // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
   function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Decode and commit decision, all against pre-edge state
   always_comb begin
      w_word_hit  = wr_en && (wr_id >= IDW'(BASE_ID)) && (wr_id < IDW'(VALID_ID));
      w_commit    = wr_en && (wr_id == IDW'(VALID_ID));
      w_idx       = wr_id - IDW'(BASE_ID);
      w_all_fresh = &r_fresh[SAMPLES-1:0];
      w_pop       = (r_count != '0) && bigreg_ready;
      w_full      = (r_count == CW'(DEPTH));
      w_accept    = w_commit && ((STRICT == 0) || w_all_fresh) && (!w_full || w_pop);
      w_reject    = w_commit && !w_accept;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_staging <= '0;
      end else begin
         for (int k = 0; k < int'(SAMPLES); k++) begin
            if (w_word_hit && (w_idx == IDW'(k))) begin
               r_staging[k*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
            end
         end
      end
   end

   // Word bits track staging; the top bit flags the cycle after an accepted commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fresh <= '0;
      end else if (w_accept) begin
         r_fresh <= {1'b1, {SAMPLES{1'b0}}};
      end else begin
         r_fresh[SAMPLES] <= 1'b0;
         for (int k = 0; k < int'(SAMPLES); k++) begin
            if (w_word_hit && (w_idx == IDW'(k))) begin
               r_fresh[k] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < int'(DEPTH); d++) begin
            r_mem[d] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_accept) begin
            r_mem[r_wr_ptr] <= r_staging;
            r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Response strobe one cycle after any in-range write; code holds between strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_valid <= 1'b0;
         r_resp       <= RESP_OKAY;
         r_reject_cnt <= '0;
      end else begin
         r_resp_valid <= w_word_hit || w_commit;
         if (w_reject) begin
            r_resp <= RESP_SLV;
         end else if (w_word_hit || w_accept) begin
            r_resp <= RESP_OKAY;
         end
         if (w_reject && (r_reject_cnt != 8'hFF)) begin
            r_reject_cnt <= r_reject_cnt + 8'd1;
         end
      end
   end

   assign wr_resp_valid = r_resp_valid;
   assign wr_resp       = r_resp;
   assign fresh         = r_fresh;
   assign bigreg_data   = r_mem[r_rd_ptr];
   assign bigreg_valid  = (r_count != '0);
   assign pending       = r_count;
   assign reject_cnt    = r_reject_cnt;

endmodule

// File: tb/tb_ps_bigreg_collector.sv
// Bench for ps_bigreg_collector: a STRICT=1 and a STRICT=0 instance share stimulus
// and are both compared every cycle against a queue-based reference model.
module tb_ps_bigreg_collector;

   localparam int W    = 16;
   localparam int S    = 16;
   localparam int BW   = 256;
   localparam int BASE = 33;
   localparam int VID  = 49;
   localparam int DEP  = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_id;
   logic [W-1:0] wr_data;
   logic       bigreg_ready;

   logic [1:0]         rv;
   logic [1:0][1:0]    rsp;
   logic [1:0][S:0]    fr;
   logic [1:0][BW-1:0] bd;
   logic [1:0]         bv;
   logic [1:0][2:0]    pend;
   logic [1:0][7:0]    rej;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, index 0 = strict instance, 1 = lax instance
   logic [W-1:0]  m_stage [2][S];
   bit            m_fresh [2][S];
   bit            m_vbit  [2];
   bit            m_rv    [2];
   logic [1:0]    m_rsp   [2];
   int            m_rej   [2];
   logic [BW-1:0] q0[$];
   logic [BW-1:0] q1[$];

   always #5 clk = ~clk;

   ps_bigreg_collector #(.STRICT(1)) u_strict (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
      .wr_resp_valid(rv[0]), .wr_resp(rsp[0]), .fresh(fr[0]), .bigreg_data(bd[0]),
      .bigreg_valid(bv[0]), .bigreg_ready(bigreg_ready), .pending(pend[0]), .reject_cnt(rej[0]));

   ps_bigreg_collector #(.STRICT(0)) u_lax (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
      .wr_resp_valid(rv[1]), .wr_resp(rsp[1]), .fresh(fr[1]), .bigreg_data(bd[1]),
      .bigreg_valid(bv[1]), .bigreg_ready(bigreg_ready), .pending(pend[1]), .reject_cnt(rej[1]));

   task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int qsize(input int s);
      return (s == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [BW-1:0] qhead(input int s);
      return (s == 0) ? q0[0] : q1[0];
   endfunction

   function automatic logic [BW-1:0] assemble(input int s);
      logic [BW-1:0] v;
      for (int k = 0; k < S; k++) v[k*W +: W] = m_stage[s][k];
      return v;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < S; k++) begin
            m_stage[s][k] = '0;
            m_fresh[s][k] = 1'b0;
         end
         m_vbit[s] = 1'b0;
         m_rv[s]   = 1'b0;
         m_rsp[s]  = 2'b00;
         m_rej[s]  = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   // Apply the current inputs to the model as one clock edge
   task automatic model_step();
      for (int s = 0; s < 2; s++) begin
         bit strict = (s == 0);
         int id = int'(wr_id);
         bit pop = (qsize(s) > 0) && bigreg_ready;
         bit push = 1'b0;
         bit allf = 1'b1;
         logic [BW-1:0] val = '0;
         m_rv[s]   = 1'b0;
         m_vbit[s] = 1'b0;
         if (wr_en && id >= BASE && id < VID) begin
            m_stage[s][id-BASE] = wr_data;
            m_fresh[s][id-BASE] = 1'b1;
            m_rv[s]  = 1'b1;
            m_rsp[s] = 2'b00;
         end else if (wr_en && id == VID) begin
            for (int k = 0; k < S; k++) if (!m_fresh[s][k]) allf = 1'b0;
            m_rv[s] = 1'b1;
            if ((!strict || allf) && (qsize(s) < DEP || pop)) begin
               push = 1'b1;
               val  = assemble(s);
               for (int k = 0; k < S; k++) m_fresh[s][k] = 1'b0;
               m_vbit[s] = 1'b1;
               m_rsp[s]  = 2'b00;
            end else begin
               m_rsp[s] = 2'b10;
               if (m_rej[s] < 255) m_rej[s]++;
            end
         end
         if (pop) begin
            if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end
         if (push) begin
            if (s == 0) q0.push_back(val); else q1.push_back(val);
         end
      end
   endtask

   task automatic check_all();
      for (int s = 0; s < 2; s++) begin
         logic [S:0] ef;
         for (int k = 0; k < S; k++) ef[k] = m_fresh[s][k];
         ef[S] = m_vbit[s];
         chk($sformatf("resp_valid%0d", s), BW'(rv[s]), BW'(m_rv[s]));
         chk($sformatf("resp%0d", s), BW'(rsp[s]), BW'(m_rsp[s]));
         chk($sformatf("fresh%0d", s), BW'(fr[s]), BW'(ef));
         chk($sformatf("valid%0d", s), BW'(bv[s]), BW'(qsize(s) > 0));
         chk($sformatf("pending%0d", s), BW'(pend[s]), BW'(qsize(s)));
         chk($sformatf("reject_cnt%0d", s), BW'(rej[s]), BW'(m_rej[s]));
         if (qsize(s) > 0) chk($sformatf("data%0d", s), bd[s], qhead(s));
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic wr(input int id, input logic [W-1:0] data);
      wr_en   = 1'b1;
      wr_id   = 8'(id);
      wr_data = data;
      cycle();
      wr_en   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic write_all(input logic [W-1:0] base);
      for (int k = 0; k < S; k++) wr(BASE + k, base + W'(k));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wr_en = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      wr_en = 1'b0; wr_id = '0; wr_data = '0; bigreg_ready = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // Full assembly and commit
      write_all(16'h1000);
      wr(VID, 16'hFFFF);
      chk("t1_resp", BW'(rsp[0]), BW'(2'b00));
      chk("t1_valid", BW'(bv[0]), BW'(1'b1));
      chk("t1_word0", BW'(bd[0][15:0]), BW'(16'h1000));
      chk("t1_word15", BW'(bd[0][255:240]), BW'(16'h100F));
      chk("t1_fresh", BW'(fr[0]), BW'(17'h10000));
      idle(1);
      chk("t1_vbit_drop", BW'(fr[0][S]), BW'(1'b0));

      // Missing last word: strict rejects, lax accepts
      for (int k = 0; k < S - 1; k++) wr(BASE + k, 16'h2000 + 16'(k));
      wr(VID, 16'h0);
      chk("t2_resp_strict", BW'(rsp[0]), BW'(2'b10));
      chk("t2_rej_strict", BW'(rej[0]), BW'(8'd1));
      chk("t2_fresh_kept", BW'(fr[0][14:0]), BW'(15'h7FFF));
      chk("t2_pending_strict", BW'(pend[0]), BW'(3'd1));
      chk("t2_resp_lax", BW'(rsp[1]), BW'(2'b00));
      bigreg_ready = 1'b1;
      idle(4);
      bigreg_ready = 1'b0;

      // Fill to DEPTH with consumer stalled, then commit with simultaneous pop
      for (int i = 0; i < 5; i++) begin
         write_all(16'h3000 + 16'(i * 16));
         wr(VID, 16'h0);
         chk("t3_resp", BW'(rsp[0]), (i < 4) ? BW'(2'b00) : BW'(2'b10));
      end
      chk("t3_pending_full", BW'(pend[0]), BW'(3'd4));
      bigreg_ready = 1'b1;
      wr(VID, 16'h0);
      chk("t3_push_pop_resp", BW'(rsp[0]), BW'(2'b00));
      chk("t3_push_pop_pend", BW'(pend[0]), BW'(3'd4));
      idle(6);
      bigreg_ready = 1'b0;

      // Lax mode commits a partly refreshed register
      wr(BASE, 16'hBEEF);
      wr(VID, 16'h0);
      chk("t4_resp_lax", BW'(rsp[1]), BW'(2'b00));
      chk("t4_word0_lax", BW'(bd[1][15:0]), BW'(16'hBEEF));
      chk("t4_word1_lax", BW'(bd[1][31:16]), BW'(16'h3041));
      chk("t4_resp_strict", BW'(rsp[0]), BW'(2'b10));

      // Out-of-range IDs are silent
      wr(32, 16'h1234);
      chk("t5_id32_norsp", BW'(rv[0]), BW'(1'b0));
      wr(50, 16'h5678);
      chk("t5_id50_norsp", BW'(rv[0]), BW'(1'b0));

      // Reset with three entries queued
      bigreg_ready = 1'b1;
      idle(6);
      bigreg_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         write_all(16'h4000 + 16'(i * 16));
         wr(VID, 16'h0);
      end
      chk("t5_pending3", BW'(pend[0]), BW'(3'd3));
      rst_n = 1'b0;
      #1;
      chk("t5_rst_pending", BW'(pend[0]), BW'(3'd0));
      chk("t5_rst_valid", BW'(bv[0]), BW'(1'b0));
      chk("t5_rst_fresh", BW'(fr[0]), BW'(17'h0));
      do_reset();
      idle(1);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         int r = int'($urandom_range(0, 99));
         int id;
         bigreg_ready = ($urandom_range(0, 3) == 0);
         if (i == 1000) begin
            do_reset();
         end else if (r < 60) begin
            wr(BASE + int'($urandom_range(0, S - 1)), W'($urandom));
         end else if (r < 72) begin
            wr(VID, W'($urandom));
         end else if (r < 80) begin
            id = int'($urandom_range(0, 255));
            if (id >= BASE && id <= VID) id = 50 + (id - BASE);
            wr(id, W'($urandom));
         end else begin
            idle(1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
